// File: rtl/haar_idwt.sv
// Single-level inverse Haar synthesis: each (a,d) pair becomes two saturated samples a+d, a-d.
// Define HAAR_IDWT_THRESH_EN to soft-threshold d by THRESH before reconstruction.
module haar_idwt #(
    parameter int DATA_WIDTH    = 8,
    parameter int SIGNAL_LENGTH = 8,
    parameter int THRESH        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_d,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done
);
    localparam int PAIRS = SIGNAL_LENGTH / 2;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam logic signed [DATA_WIDTH:0] SMAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0] SMIN = {2'b11, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCEPT, EMIT0, EMIT1, FIN} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        pair_cnt;
    logic [DATA_WIDTH-1:0]   x0, x1;
    logic                    capture, cnt_clr, cnt_inc;
    logic signed [DATA_WIDTH:0] a_ext, d_ext, d_thr, sum, dif;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] v);
        if (v > SMAX)      return SMAX[DATA_WIDTH-1:0];
        else if (v < SMIN) return SMIN[DATA_WIDTH-1:0];
        else               return v[DATA_WIDTH-1:0];
    endfunction

    assign a_ext = {din_a[DATA_WIDTH-1], din_a};
    assign d_ext = {din_d[DATA_WIDTH-1], din_d};

`ifdef HAAR_IDWT_THRESH_EN
    localparam logic signed [DATA_WIDTH:0] TH = (DATA_WIDTH+1)'(THRESH);
    // Shrinking towards zero never grows |d|, so DATA_WIDTH+1 bits still suffice.
    always_comb begin
        d_thr = '0;
        if (d_ext > TH)       d_thr = d_ext - TH;
        else if (d_ext < -TH) d_thr = d_ext + TH;
    end
`else
    logic unused_thresh;
    assign unused_thresh = (THRESH != 0);
    assign d_thr = d_ext;
`endif

    assign sum = a_ext + d_thr;
    assign dif = a_ext - d_thr;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE:   if (start) begin
                        state_nxt = ACCEPT;
                        cnt_clr   = 1'b1;
                    end
            ACCEPT: if (din_valid) begin
                        state_nxt = EMIT0;
                        capture   = 1'b1;
                    end
            EMIT0:  if (dout_ready) state_nxt = EMIT1;
            EMIT1:  if (dout_ready) begin
                        if (pair_cnt == LAST_PAIR) begin
                            state_nxt = FIN;
                        end else begin
                            state_nxt = ACCEPT;
                            cnt_inc   = 1'b1;
                        end
                    end
            FIN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pair_cnt <= '0;
            x0       <= '0;
            x1       <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)      pair_cnt <= '0;
            else if (cnt_inc) pair_cnt <= pair_cnt + 1'b1;
            if (capture) begin
                x0 <= sat(sum);
                x1 <= sat(dif);
            end
        end
    end

    // Outputs decode from state and the held sample registers only, so they hold under backpressure.
    assign din_ready  = (state == ACCEPT);
    assign dout_valid = (state == EMIT0) || (state == EMIT1);
    assign done       = (state == FIN);
    assign dout       = (state == EMIT0) ? x0 : (state == EMIT1) ? x1 : '0;
endmodule

// File: tb/tb_haar_idwt.sv
// Randomized self-checking bench for haar_idwt against an integer reconstruction model.
module tb_haar_idwt;
    localparam int W  = 8;
    localparam int L  = 8;
    localparam int NP = L / 2;
`ifdef HAAR_IDWT_THRESH_EN
    localparam int TH = 2;
`else
    localparam int TH = 0;
`endif

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
    logic [W-1:0] din_a = '0, din_d = '0;
    logic         din_ready, dout_valid, done;
    logic [W-1:0] dout;

    haar_idwt #(.DATA_WIDTH(W), .SIGNAL_LENGTH(L), .THRESH(TH)) dut (
        .clk(clk), .rst(rst), .start(start), .din_a(din_a), .din_d(din_d),
        .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0, tmo = 0, done_cnt = 0, cyc = 0;
    int pa[NP], pd[NP];
    int got[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Reference: x0 = a+d', x1 = a-d', clamped to the signed W-bit range.
    function automatic int ref_x(input int a, input int d, input bit odd);
        int dd, s;
        dd = d;
`ifdef HAAR_IDWT_THRESH_EN
        if (d > TH)       dd = d - TH;
        else if (d < -TH) dd = d + TH;
        else              dd = 0;
`endif
        s = odd ? a - dd : a + dd;
        if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
        if (s < -(1 << (W-1)))    s = -(1 << (W-1));
        return s;
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
    endfunction

    // All stimulus tasks start and end #1 after a rising edge.
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pairs(input int first, input int n, input bit rnd);
        for (int i = first; i < first + n; i++) begin
            int t = 0;
            while (din_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
            if (din_ready !== 1'b1) tmo++;
            din_a = W'(pa[i]); din_d = W'(pd[i]); din_valid = 1'b1;
            @(posedge clk); #1;
            din_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                t = 0;
                forever begin
                    dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (dout_valid === 1'b1 && dout_ready) begin
                        got.push_back(int'($signed(dout)));
                        @(posedge clk); #1;
                        break;
                    end
                    @(posedge clk); #1;
                    t++;
                    if (t > 20) begin tmo++; break; end
                end
            end
            dout_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        start = 1'b1; din_valid = 1'b1; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({din_ready, dout_valid, done, dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {din_ready, dout_valid, done, dout});
        end
        start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b vld=%b required 0 0", din_ready, dout_valid);
        end
    endtask

    // Pairs (1,0),(5,-1),(9,2),(13,0) -> 1,1,4,6,11,7,13,13 at full rate.
    task automatic test_basic();
        int c0, d0;
        pa = '{1, 5, 9, 13}; pd = '{0, -1, 2, 0};
        got.delete(); tmo = 0; d0 = done_cnt; c0 = cyc;
        start_pulse();
        drive_pairs(0, NP, 1'b0);
        vectors++;
        if (cyc - c0 !== 1 + 3 * NP) begin
            errors++;
            $display("FAIL basic_cycles got %0d required %0d", cyc - c0, 1 + 3 * NP);
        end
        vectors++;
        if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b required 1", done); end
        vectors++;
        if (got.size() !== L) begin errors++; $display("FAIL basic_len got %0d required %0d", got.size(), L); end
        for (int i = 0; i < got.size() && i < L; i++) begin
            int e = ref_x(pa[i/2], pd[i/2], 1'(i % 2));
            vectors++;
            if (got[i] !== e) begin errors++; $display("FAIL basic_sample[%0d] got %0d required %0d", i, got[i], e); end
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done_once got done=%b pulses=%0d required 0 1", done, done_cnt - d0);
        end
        vectors++;
        if (tmo !== 0) begin errors++; $display("FAIL basic_timeout got %0d required 0", tmo); end
    endtask

    // (100,50) -> 127,50 ; (-100,50) -> -50,-128 ; plus both rails.
    task automatic test_saturation();
        pa = '{100, -100, 127, -128}; pd = '{50, 50, 127, -128};
        got.delete(); tmo = 0;
        start_pulse();
        drive_pairs(0, NP, 1'b1);
        for (int i = 0; i < L; i++) begin
            int e = ref_x(pa[i/2], pd[i/2], 1'(i % 2));
            vectors++;
            if (i >= got.size() || got[i] !== e) begin
                errors++;
                $display("FAIL sat_sample[%0d] got %0d required %0d", i, (i < got.size()) ? got[i] : 9999, e);
            end
        end
        vectors++;
        if (tmo !== 0 || done !== 1'b1) begin errors++; $display("FAIL sat_end got tmo=%0d done=%b required 0 1", tmo, done); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int a, d, e0, e1;
        a = rnd_s(); d = rnd_s();
        e0 = ref_x(a, d, 1'b0); e1 = ref_x(a, d, 1'b1);
        start_pulse();
        din_a = W'(a); din_d = W'(d); din_valid = 1'b1;
        @(posedge clk); #1;
        din_a = ~din_a; din_d = ~din_d;
        dout_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (dout_valid !== 1'b1 || int'($signed(dout)) !== e0 || din_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] got vld=%b dout=%0d rdy=%b required 1 %0d 0",
                         c, dout_valid, $signed(dout), din_ready, e0);
            end
            @(posedge clk); #1;
        end
        din_valid = 1'b0; dout_ready = 1'b1;
        vectors++;
        if (int'($signed(dout)) !== e0) begin errors++; $display("FAIL stall_x0 got %0d required %0d", $signed(dout), e0); end
        @(posedge clk); #1;
        vectors++;
        if (dout_valid !== 1'b1 || int'($signed(dout)) !== e1) begin
            errors++; $display("FAIL stall_x1 got vld=%b dout=%0d required 1 %0d", dout_valid, $signed(dout), e1);
        end
        @(posedge clk); #1;
        dout_ready = 1'b0;
        vectors++;
        if (din_ready !== 1'b1) begin errors++; $display("FAIL stall_next_accept got %b required 1", din_ready); end
        rst = 1'b0; #2 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_midframe_reset();
        int d0;
        for (int i = 0; i < NP; i++) begin pa[i] = rnd_s(); pd[i] = rnd_s(); end
        got.delete(); tmo = 0; d0 = done_cnt;
        start_pulse();
        drive_pairs(0, 2, 1'b1);
        din_a = W'(pa[2]); din_d = W'(pd[2]); din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        vectors++;
        if (dout_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_vld got %b required 1", dout_valid); end
        rst = 1'b0; #1;
        vectors++;
        if ({din_ready, dout_valid, done, dout} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got %b required 0", {din_ready, dout_valid, done, dout});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        din_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
                errors++; $display("FAIL mid_needs_start got rdy=%b vld=%b required 0 0", din_ready, dout_valid);
            end
        end
        din_valid = 1'b0;
        vectors++;
        if (done_cnt !== d0) begin errors++; $display("FAIL mid_no_done got %0d required %0d", done_cnt - d0, 0); end
        for (int i = 0; i < NP; i++) begin pa[i] = rnd_s(); pd[i] = rnd_s(); end
        got.delete();
        start_pulse();
        drive_pairs(0, NP, 1'b1);
        for (int i = 0; i < L; i++) begin
            int e = ref_x(pa[i/2], pd[i/2], 1'(i % 2));
            vectors++;
            if (i >= got.size() || got[i] !== e) begin
                errors++; $display("FAIL mid_after[%0d] got %0d required %0d", i, (i < got.size()) ? got[i] : 9999, e);
            end
        end
        vectors++;
        if (done !== 1'b1 || tmo !== 0) begin errors++; $display("FAIL mid_after_done got done=%b tmo=%0d required 1 0", done, tmo); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore();
        for (int i = 0; i < NP; i++) begin pa[i] = rnd_s(); pd[i] = rnd_s(); end
        got.delete(); tmo = 0;
        start_pulse();
        drive_pairs(0, 2, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++; $display("FAIL ign_start_accept got rdy=%b vld=%b required 1 0", din_ready, dout_valid);
        end
        drive_pairs(2, NP - 2, 1'b1);
        vectors++;
        if (done !== 1'b1) begin errors++; $display("FAIL ign_len_done got %b required 1", done); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (din_ready !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ign_start_fin got rdy=%b done=%b required 0 0", din_ready, done);
        end
        din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
                errors++; $display("FAIL ign_idle_valid got rdy=%b vld=%b required 0 0", din_ready, dout_valid);
            end
        end
        din_valid = 1'b0;
        for (int i = 0; i < L; i++) begin
            int e = ref_x(pa[i/2], pd[i/2], 1'(i % 2));
            vectors++;
            if (i >= got.size() || got[i] !== e) begin
                errors++; $display("FAIL ign_sample[%0d] got %0d required %0d", i, (i < got.size()) ? got[i] : 9999, e);
            end
        end
        vectors++;
        if (tmo !== 0) begin errors++; $display("FAIL ign_timeout got %0d required 0", tmo); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int d0 = done_cnt;
            for (int i = 0; i < NP; i++) begin pa[i] = rnd_s(); pd[i] = rnd_s(); end
            got.delete(); tmo = 0;
            start_pulse();
            drive_pairs(0, NP, 1'b1);
            for (int i = 0; i < L; i++) begin
                int e = ref_x(pa[i/2], pd[i/2], 1'(i % 2));
                vectors++;
                if (i >= got.size() || got[i] !== e) begin
                    errors++; $display("FAIL rnd%0d[%0d] got %0d required %0d", f, i, (i < got.size()) ? got[i] : 9999, e);
                end
            end
            @(posedge clk); #1;
            vectors++;
            if (done_cnt - d0 !== 1 || tmo !== 0) begin
                errors++; $display("FAIL rnd%0d_done got pulses=%0d tmo=%0d required 1 0", f, done_cnt - d0, tmo);
            end
        end
    endtask

`ifdef HAAR_IDWT_THRESH_EN
    // THRESH=2: (10,1) -> 10,10 ; (10,-5) -> 7,13.
    task automatic test_thresh();
        int exp_s[4];
        exp_s = '{10, 10, 7, 13};
        pa = '{10, 10, 0, 0}; pd = '{1, -5, 2, -3};
        got.delete(); tmo = 0;
        start_pulse();
        drive_pairs(0, NP, 1'b1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp_s[i]) begin
                errors++; $display("FAIL thresh[%0d] got %0d required %0d", i, (i < got.size()) ? got[i] : 9999, exp_s[i]);
            end
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_midframe_reset();
        test_ignore();
        test_random();
`ifdef HAAR_IDWT_THRESH_EN
        test_thresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
